time_core: RTL and testbench
============================

Name: time_core

Overview:
Timekeeping counter at the far end of the time-setup interface. It consumes the setup block's packed time word and load strobe, and keeps running hours:minutes:seconds from a clock prescaler. Its output data_ch feeds the display path and the setup block's data_ch input.

Parameters:
TICKS_PER_SEC, 50000000, clock cycles per second; minimum 2.
PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
setup_data  in  24  time to load: [23:16] hours, [15:8] minutes, [7:0] seconds; binary per byte.
setup_imp  in  1  load strobe, level, may stay high for many cycles; the block acts on its rising edge only.
run_en  in  1  1 = time advances; 0 = prescaler and time frozen.
data_ch  out  24  current time, same packing as setup_data.
sec_pulse  out  1  one-cycle pulse on every second increment.
day_wrap  out  1  one-cycle pulse when 23:59:59 rolls to 00:00:00.
load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=1 at a clock edge): data_ch=0, prescaler=0, sec_pulse=0, day_wrap=0, load_err=0, imp_q=0. All outputs are registered.
- Edge detect: imp_q samples setup_imp every cycle. load_req = setup_imp & ~imp_q. imp_q=0 after reset, so a setup_imp already high when reset releases counts as one edge.
- Valid load:
  - Condition: load_req and setup_data has sec<=59, min<=59, hr<=23.
  - Next cycle: data_ch=setup_data, prescaler=0, sec_pulse=0.
- Invalid load:
  - Condition: load_req with any field out of range.
  - data_ch is unchanged; load_err=1 for one cycle.
  - The prescaler still clears, so a rejected load restarts the current second.
- Counting (no load_req, run_en=1):
  - The prescaler increments each cycle.
  - At prescaler==TICKS_PER_SEC-1 the prescaler goes to 0, time advances by one second, and sec_pulse=1 in the same cycle the new data_ch appears.
- Advance rules:
  - sec 59->0 carries into min.
  - min 59->0 carries into hr.
  - hr 23->0 sets day_wrap=1 in the same cycle as 00:00:00 appears.
- Sequential digit updates within a cycle are not permitted; all three fields update atomically in one edge.
- run_en=0: prescaler and data_ch hold and no pulses are produced; loads still act. When run_en returns to 1, counting resumes from the held prescaler value.
- Priority per cycle: reset > load_req > second tick. A tick that coincides with load_req is discarded, with no sec_pulse and no day_wrap.
- Reset in mid-second or mid-load clears everything; a pending edge is lost unless setup_imp is still high after reset, which the edge-detect rule above then treats as a new edge.
- Fields are never observed out of range at data_ch.

Optional Feature:
Macro ALARM_EN.
- Defined: adds alarm_time in 24 (same packing) and alarm_hit out 1.
- alarm_hit pulses one cycle when a second tick produces data_ch == alarm_time.
- A load that lands on alarm_time does not fire; only a tick does.
- Reset value of alarm_hit is 0.
- Undefined: neither port exists and there is no compare logic.

Test Plan:
1. TICKS_PER_SEC=4, reset, run_en=1 -> data_ch=0x000000; sec_pulse every 4th cycle; after 4 pulses data_ch=0x000004.
2. setup_imp rises with setup_data=0x173B3B (23:59:59) -> next cycle data_ch=0x173B3B. Four cycles later data_ch=0x000000 with sec_pulse=1 and day_wrap=1 together.
3. setup_imp held high 20 cycles with setup_data=0x0A0000, then setup_data changes to 0x0B0000 while still high -> exactly one load; data_ch stays 0x0A00xx counting.
4. setup_data=0x18003C (hr=24, sec=60), setup_imp rises -> load_err=1 for one cycle; data_ch unchanged; prescaler restarted at 0.
5. setup_imp rise in the same cycle the prescaler reaches 3 with setup_data=0x010203 -> data_ch=0x010203 and no sec_pulse. After that, exactly 4 cycles pass to 0x010204.
6. run_en=0 for 10 cycles at prescaler=2 -> data_ch frozen, no pulses. After run_en=1, the next sec_pulse comes 2 cycles later. With ALARM_EN and alarm_time=0x010205, alarm_hit pulses with that tick.

Source files
------------

// File: rtl/time_core.sv
// time_core: running hh:mm:ss counter fed by a clock prescaler.
// Ports: clock, reset (sync, active-high); setup_data[23:0] (hr:min:sec
// bytes), setup_imp (load strobe, rising edge acts), run_en (advance
// enable); data_ch[23:0] current time; sec_pulse, day_wrap, load_err
// one-cycle pulses. Optional macro ALARM_EN adds alarm_time[23:0] in
// and alarm_hit out (pulse when a tick lands on alarm_time).
module time_core #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] setup_data,
  input  logic        setup_imp,
  input  logic        run_en,
`ifdef ALARM_EN
  input  logic [23:0] alarm_time,
  output logic        alarm_hit,
`endif
  output logic [23:0] data_ch,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        load_err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST =
    PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         hr_q, hr_d;
  logic [7:0]         min_q, min_d;
  logic [7:0]         sec_q, sec_d;
  logic               imp_q, imp_d;
  logic               sec_pulse_q, sec_pulse_d;
  logic               day_wrap_q, day_wrap_d;
  logic               load_err_q, load_err_d;

  logic               load_req;
  logic               load_ok;
  logic               tick;
  logic               sel_load;
  logic               sel_tick;
  logic               sel_count;

  logic [7:0]         hr_inc;
  logic [7:0]         min_inc;
  logic [7:0]         sec_inc;
  logic               wrap_inc;

  assign load_req = setup_imp & ~imp_q;

  assign load_ok = (setup_data[23:16] <= 8'd23) &&
                   (setup_data[15:8]  <= 8'd59) &&
                   (setup_data[7:0]   <= 8'd59);

  assign tick = run_en && (presc_q == PRESC_LAST);

  // Mutually exclusive selects: a load always beats a tick.
  assign sel_load  = load_req;
  assign sel_tick  = ~load_req & tick;
  assign sel_count = ~load_req & run_en & ~tick;

  // Full carry chain computed in parallel so all fields move together.
  always_comb begin
    sec_inc  = sec_q;
    min_inc  = min_q;
    hr_inc   = hr_q;
    wrap_inc = 1'b0;
    if (sec_q == 8'd59) begin
      sec_inc = 8'd0;
      if (min_q == 8'd59) begin
        min_inc = 8'd0;
        if (hr_q == 8'd23) begin
          hr_inc   = 8'd0;
          wrap_inc = 1'b1;
        end else begin
          hr_inc = hr_q + 8'd1;
        end
      end else begin
        min_inc = min_q + 8'd1;
      end
    end else begin
      sec_inc = sec_q + 8'd1;
    end
  end

  always_comb begin
    presc_d     = presc_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    imp_d       = setup_imp;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;
    load_err_d  = 1'b0;
    unique case (1'b1)
      sel_load: begin
        // Rejected loads still restart the current second.
        presc_d = '0;
        if (load_ok) begin
          hr_d  = setup_data[23:16];
          min_d = setup_data[15:8];
          sec_d = setup_data[7:0];
        end else begin
          load_err_d = 1'b1;
        end
      end
      sel_tick: begin
        presc_d     = '0;
        hr_d        = hr_inc;
        min_d       = min_inc;
        sec_d       = sec_inc;
        sec_pulse_d = 1'b1;
        day_wrap_d  = wrap_inc;
      end
      sel_count: begin
        presc_d = presc_q + PRESC_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q     <= '0;
      hr_q        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      imp_q       <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      imp_q       <= imp_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign data_ch   = {hr_q, min_q, sec_q};
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

`ifdef ALARM_EN
  logic alarm_hit_q, alarm_hit_d;

  // Only a tick can fire; loads never compare.
  always_comb begin
    alarm_hit_d = sel_tick &&
      ({hr_inc, min_inc, sec_inc} == alarm_time);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: tb/tb_time_core.sv
// tb_time_core: scoreboard bench for time_core, TICKS_PER_SEC=4.
// Stimulus queues expected events; a negedge monitor checks them.
module tb_time_core;

  logic        clock;
  logic        reset;
  logic [23:0] setup_data;
  logic        setup_imp;
  logic        run_en;
  logic [23:0] data_ch;
  logic        sec_pulse;
  logic        day_wrap;
  logic        load_err;
`ifdef ALARM_EN
  logic [23:0] alarm_time;
  logic        alarm_hit;
  localparam bit HAS_ALARM = 1'b1;
`else
  localparam bit HAS_ALARM = 1'b0;
`endif

  time_core #(
    .TICKS_PER_SEC(4),
    .PRESC_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .setup_data(setup_data),
    .setup_imp(setup_imp),
    .run_en(run_en),
`ifdef ALARM_EN
    .alarm_time(alarm_time),
    .alarm_hit(alarm_hit),
`endif
    .data_ch(data_ch),
    .sec_pulse(sec_pulse),
    .day_wrap(day_wrap),
    .load_err(load_err)
  );

  // flags = {sec_pulse, day_wrap, load_err, alarm_hit}
  typedef struct {
    int          cyc;
    logic [23:0] data;
    logic [3:0]  flags;
  } ev_t;

  ev_t         q[$];
  int          n;
  int          pass_cnt;
  int          total_cnt;
  bit          armed;
  logic [23:0] prev;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial n = 0;
  always @(posedge clock) n <= n + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, n);
  endtask

  task automatic push(input int c, input logic [23:0] d,
                      input logic [3:0] f);
    ev_t e;
    e.cyc   = c;
    e.data  = d;
    e.flags = f;
    q.push_back(e);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] cur_flags();
    logic a;
    a = 1'b0;
`ifdef ALARM_EN
    a = alarm_hit;
`endif
    return {sec_pulse, day_wrap, load_err, a};
  endfunction

  always @(negedge clock) begin
    ev_t        e;
    logic [3:0] f;
    f = cur_flags();
    if (armed && !reset && (f != 4'd0 || data_ch !== prev)) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_event: data 0x%0h flags %b at cycle %0d",
                 data_ch, f, n);
      end else begin
        e = q.pop_front();
        chk("ev_cycle", 32'(n), 32'(e.cyc));
        chk("ev_data", {8'd0, data_ch}, {8'd0, e.data});
        chk("ev_flags", {28'd0, f}, {28'd0, e.flags});
      end
    end
    prev = data_ch;
  end

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    armed      = 1'b0;
    prev       = '0;
    reset      = 1'b1;
    setup_data = '0;
    setup_imp  = 1'b0;
    run_en     = 1'b1;
`ifdef ALARM_EN
    alarm_time = 24'h010205;
`endif
    step(3);
    // n=3: reset state
    chk("rst_data", {8'd0, data_ch}, 32'd0);
    chk("rst_flags", {28'd0, cur_flags()}, 32'd0);
    reset = 1'b0;
    armed = 1'b1;

    // 1: ticks every 4 cycles
    push(7,  24'h000001, 4'b1000);
    push(11, 24'h000002, 4'b1000);
    push(15, 24'h000003, 4'b1000);
    push(19, 24'h000004, 4'b1000);
    step(16);
    chk("after4_data", {8'd0, data_ch}, 32'h000004);

    // 2: load 23:59:59, day wrap
    setup_data = 24'h173B3B;
    setup_imp  = 1'b1;
    push(20, 24'h173B3B, 4'b0000);
    push(24, 24'h000000, 4'b1100);
    step(1);
    setup_imp = 1'b0;
    step(4);

    // 3: strobe held high, one load only
    setup_data = 24'h0A0000;
    setup_imp  = 1'b1;
    push(25, 24'h0A0000, 4'b0000);
    push(29, 24'h0A0001, 4'b1000);
    push(33, 24'h0A0002, 4'b1000);
    push(37, 24'h0A0003, 4'b1000);
    push(41, 24'h0A0004, 4'b1000);
    push(45, 24'h0A0005, 4'b1000);
    step(10);
    setup_data = 24'h0B0000;
    step(10);
    setup_imp = 1'b0;
    step(1);

    // 4: rejected load at prescaler=2 restarts the second
    step(2);
    setup_data = 24'h18003C;
    setup_imp  = 1'b1;
    push(48, 24'h0A0005, 4'b0010);
    push(52, 24'h0A0006, 4'b1000);
    step(1);
    setup_imp = 1'b0;
    step(4);

    // 5: load coincides with tick
    step(3);
    setup_data = 24'h010203;
    setup_imp  = 1'b1;
    push(56, 24'h010203, 4'b0000);
    push(60, 24'h010204, 4'b1000);
    step(1);
    setup_imp = 1'b0;
    step(4);

    // 6: freeze at prescaler=2
    step(2);
    run_en = 1'b0;
    step(10);
    run_en = 1'b1;
    push(74, 24'h010205, {3'b100, HAS_ALARM});
    push(78, 24'h010206, 4'b1000);
    step(7);
    chk("final_data", {8'd0, data_ch}, 32'h010206);
    chk("queue_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
